// File: rtl/coriolis_ker1_subker1_offbuf.sv
// coriolis_ker1_subker1_offbuf: pairs x[i] with x[i+OFFSET] for the ker1/subker1 adder.
// Define OFFBUF_CLAMP_EN to pad the lookahead stream with the last element instead of 0.
module coriolis_ker1_subker1_offbuf #(
    parameter int STREAMW = 34,
    parameter int OFFSET  = 16,
    parameter int NELEM   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STREAMW-1:0] in1_s0,
    input  logic               ivalid,
    output logic               iready,
    output logic [STREAMW-1:0] out1_s0,
    output logic [STREAMW-1:0] out2_s0,
    output logic               ovalid_out1_s0,
    output logic               ovalid_out2_s0,
    input  logic               oready,
    output logic               eos
);
    localparam int CW = $clog2(NELEM + 1);
    localparam int PW = (OFFSET > 1) ? $clog2(OFFSET) : 1;
    localparam logic [CW-1:0] OFF_C   = CW'(OFFSET);
    localparam logic [CW-1:0] NEL_C   = CW'(NELEM);
    localparam logic [CW-1:0] LAST_C  = CW'(NELEM - 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(OFFSET - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               obuf_v_q, obuf_v_d, eos_q, eos_d;
    logic [STREAMW-1:0] out1_q, out1_d, out2_q, out2_d, pad;
    logic [STREAMW-1:0] mem_q [OFFSET];
    logic               adv, acc, load, last;

`ifdef OFFBUF_CLAMP_EN
    logic [STREAMW-1:0] last_x_q, last_x_d;
    always_comb last_x_d = acc ? in1_s0 : last_x_q;
    always_ff @(posedge clk) last_x_q <= rst ? '0 : last_x_d;
    assign pad = last_x_q;
`else
    assign pad = '0;
`endif

    // RUN loads a pair per accept; DRAIN loads a padded pair per output slot
    always_comb begin
        adv       = ~obuf_v_q | oready;
        iready    = (state_q == FILL) | ((state_q == RUN) & adv);
        acc       = ivalid & iready;
        load      = (state_q == RUN) ? acc : ((state_q == DRAIN) & adv);
        last      = (state_q == DRAIN) & (out_cnt_q == LAST_C);
        ptr_d     = (acc | load) ? ((ptr_q == PTR_MAX) ? '0 : ptr_q + PW'(1)) : ptr_q;
        in_cnt_d  = acc ? in_cnt_q + CW'(1) : in_cnt_q;
        out_cnt_d = load ? out_cnt_q + CW'(1) : out_cnt_q;
        out1_d    = load ? mem_q[ptr_q] : out1_q;
        out2_d    = load ? ((state_q == DRAIN) ? pad : in1_s0) : out2_q;
        obuf_v_d  = load | (obuf_v_q & ~oready);
        eos_d     = load ? last : (eos_q & ~(obuf_v_q & oready));
        state_d   = state_q;
        if ((state_q == FILL) && acc && (in_cnt_d == OFF_C)) state_d = RUN;
        if ((state_q == RUN) && acc && (in_cnt_d == NEL_C)) state_d = DRAIN;
        if (load && last) begin
            state_d   = FILL;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ptr_q     <= '0;
            obuf_v_q  <= 1'b0;
            eos_q     <= 1'b0;
            out1_q    <= '0;
            out2_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ptr_q     <= ptr_d;
            obuf_v_q  <= obuf_v_d;
            eos_q     <= eos_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
        end
    end

    // Read-before-write: the slot read for out1 is refilled with the newest element
    always_ff @(posedge clk) if (acc) mem_q[ptr_q] <= in1_s0;

    assign out1_s0        = out1_q;
    assign out2_s0        = out2_q;
    assign ovalid_out1_s0 = obuf_v_q;
    assign ovalid_out2_s0 = obuf_v_q;
    assign eos            = eos_q;
endmodule

// File: tb/tb_coriolis_ker1_subker1_offbuf.sv
// tb_coriolis_ker1_subker1_offbuf: directed streams with a queue of expected pairs.
module tb_coriolis_ker1_subker1_offbuf;
    localparam int W = 34, OFF = 2, NE = 6;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         e;
    } pair_t;

    logic         clk = 1'b0, rst = 1'b1, ivalid = 1'b0, oready = 1'b1;
    logic [W-1:0] in1_s0 = '0;
    logic         iready, ov1, ov2, eos;
    logic [W-1:0] out1, out2;
    pair_t        sb[$];
    int           n_chk = 0, n_pass = 0, cyc = 0, pops = 0;
    int           acc3_cyc = -1, acc2_cyc = -1, first_pop = -1, last_pop = -1, eos_pop = -1;

    coriolis_ker1_subker1_offbuf #(.STREAMW(W), .OFFSET(OFF), .NELEM(NE)) dut (
        .clk(clk), .rst(rst), .in1_s0(in1_s0), .ivalid(ivalid), .iready(iready),
        .out1_s0(out1), .out2_s0(out2), .ovalid_out1_s0(ov1), .ovalid_out2_s0(ov2),
        .oready(oready), .eos(eos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] pad_of(input int base);
`ifdef OFFBUF_CLAMP_EN
        return W'(base + NE - 1);
`else
        return '0;
`endif
    endfunction

    task automatic push_stream(input int base);
        pair_t p;
        for (int i = 0; i < NE; i++) begin
            p.a = W'(base + i);
            p.b = (i + OFF < NE) ? W'(base + i + OFF) : pad_of(base);
            p.e = (i == NE - 1);
            sb.push_back(p);
        end
    endtask

    // base2 > 0 appends a second stream back-to-back; abort stops once (x4,pad) is on the outputs
    task automatic run(input int base, input int base2, input bit gap, input bit fill_lo,
                       input bit stall, input bit abort);
        int n, idx, stall_n, budget;
        bit phase, st;
        pair_t p;
        n = (base2 > 0) ? 2 * NE : NE;
        idx = 0; stall_n = 0; budget = 200; phase = 1'b0;
        push_stream(base);
        if (base2 > 0) push_stream(base2);
        acc3_cyc = -1; acc2_cyc = -1; first_pop = -1; eos_pop = -1;
        while ((idx < n || sb.size() > 0) && budget > 0) begin
            in1_s0 = (idx < NE) ? W'(base + idx) : W'(base2 + idx - NE);
            ivalid = (idx < n) && !(gap && phase);
            oready = 1'b1;
            st = 1'b0;
            if (abort && ov1 && out1 == W'(base + 4)) begin
                ivalid = 1'b0;
                oready = 1'b0;
                break;
            end
            if (fill_lo && idx < OFF) oready = 1'b0;
            if (stall && ov1 && out1 == W'(base + 1) && stall_n < 3) begin
                oready = 1'b0;
                stall_n++;
                st = 1'b1;
            end
            #1;
            if (fill_lo && idx < OFF) chk("fill_iready", iready, 1);
            if (st) begin
                chk("stall_iready", iready, 0);
                chk("hold_out2", out2, W'(base + 3));
                chk("hold_eos", eos, 0);
            end
            if (ivalid && iready) begin
                if (idx == 2) acc3_cyc = cyc;
                if (idx == NE) acc2_cyc = cyc;
                idx++;
            end
            if (ov1 && oready) begin
                chk("ovalid2", ov2, 1);
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    p = sb.pop_front();
                    chk($sformatf("pair%0d.out1", pops), out1, p.a);
                    chk($sformatf("pair%0d.out2", pops), out2, p.b);
                    chk($sformatf("pair%0d.eos", pops), eos, p.e);
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    if (p.e && eos_pop < 0) eos_pop = cyc;
                    pops++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            phase = !phase;
            budget--;
        end
        if (!abort) chk("stream_done", (idx == n) && (sb.size() == 0), 1);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_ovalid1", ov1, 0);
        chk("rst_ovalid2", ov2, 0);
        chk("rst_eos", eos, 0);
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_iready", iready, 1);

        run(1, 0, 0, 0, 0, 0);
        chk("first_latency", first_pop - acc3_cyc, 1);
        chk("back_to_back", last_pop - first_pop, NE - 1);

        run(1, 0, 0, 1, 1, 0);

        run(1, 0, 1, 0, 0, 0);
        chk("gap_latency", first_pop - acc3_cyc, 1);

        run(1, 11, 0, 0, 0, 0);
        chk("restart_cycle", acc2_cyc, eos_pop);

        run(1, 0, 0, 0, 0, 1);
        chk("abort_held_out1", out1, 5);
        sb.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ovalid", ov1, 0);
        chk("mid_rst_eos", eos, 0);
        chk("mid_rst_iready", iready, 1);
        run(1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/coriolis_ker1_subker1_offbuf.md
Name: coriolis_ker1_subker1_offbuf

Overview:
Upstream feeder for the coriolis ker1/subker1 FP adder stage. Takes one scalar stream x[0..NELEM-1] and emits two aligned streams, out1 = x[i] and out2 = x[i+OFFSET], for i = 0..NELEM-1. Lookahead elements beyond the end of the stream are padded. Outputs connect directly to the adder's in1_s0/in2_s0 and its per-input ivalids; the adder's iready drives this block's oready.

Parameters:
STREAMW, 34, element width (FloPoCo format: 2 exception bits plus fp32)
OFFSET, 16, lookahead distance in elements; legal range 1 <= OFFSET < NELEM
NELEM, 1024, elements per stream (one grid row/plane)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in1_s0  in  STREAMW  input element
ivalid  in  1  in1_s0 valid
iready  out  1  block accepts in1_s0 this cycle
out1_s0  out  STREAMW  x[i] (registered)
out2_s0  out  STREAMW  x[i+OFFSET] or pad (registered)
ovalid_out1_s0  out  1  out1_s0 valid
ovalid_out2_s0  out  1  out2_s0 valid; always identical to ovalid_out1_s0
oready  in  1  downstream ready
eos  out  1  end of stream; high together with ovalid on the last pair (i = NELEM-1)

Behaviour:
- Reset is synchronous on clk (active-high rst). After reset: state=FILL; in_cnt, out_cnt and ptr = 0; obuf_v=0; out1_s0, out2_s0 = 0; ovalid_*=0; eos=0. Buffer contents are don't-care.
- Storage: circular buffer of OFFSET entries, pointer ptr wraps OFFSET-1 -> 0. Reading buf[ptr] and writing buf[ptr] in the same cycle returns the old data.
- Output register: obuf_v, out1_s0, out2_s0. adv = ~obuf_v | oready. ovalid_out1_s0 = ovalid_out2_s0 = obuf_v.
- Output hold: while obuf_v=1 and oready=0, out1_s0, out2_s0 and eos hold their values.
- Output clear: obuf_v clears on oready=1 when no new pair is loaded that cycle.
- Accept: acc = ivalid & iready.
- FILL:
  - iready = 1, independent of oready.
  - On acc: buf[ptr] <= in1_s0; ptr++; in_cnt++. No output is produced.
  - in_cnt reaching OFFSET -> RUN.
- RUN:
  - iready = adv.
  - On acc: out1_s0 <= buf[ptr]; out2_s0 <= in1_s0; buf[ptr] <= in1_s0; ptr++; in_cnt++; out_cnt++; obuf_v <= 1.
  - in_cnt reaching NELEM -> DRAIN.
- DRAIN:
  - iready = 0.
  - On adv: out1_s0 <= buf[ptr]; out2_s0 <= pad; ptr++; out_cnt++; obuf_v <= 1.
  - After the pair with out_cnt = NELEM-1 is loaded: eos set on that pair; in_cnt, out_cnt and ptr cleared; state -> FILL.
  - A new stream may be accepted on the next cycle, while the final pair is still held.
- Latency: an output pair is visible one cycle after its triggering accept (RUN) or adv (DRAIN).
- Throughput: one pair per cycle with oready held high; no bubbles at the RUN->DRAIN transition.
- Gaps on ivalid: produce no output, and state and counters hold.
- Pad value: 0 unless OFFBUF_CLAMP_EN is defined.
- eos: set when the last pair is loaded; cleared when that pair is consumed, unless another load replaces it.
- Reset in any state, including mid-DRAIN with a held pair: immediate return to reset values; the partial stream is discarded.
- Counter widths: clog2(NELEM+1) bits. Pointer width: max(1, clog2(OFFSET)) bits.

Optional Feature:
OFFBUF_CLAMP_EN
- Defined:
  - A register last_x captures every accepted in1_s0.
  - DRAIN pads out2_s0 with last_x, i.e. x[NELEM-1] (clamp boundary).
  - last_x resets to 0.
- Undefined: pad is constant 0 and no last_x register exists.

Test Plan:
- OFFSET=2, NELEM=6, input 1..6 back-to-back, oready=1 -> pairs (1,3),(2,4),(3,5),(4,6),(5,0),(6,0). Pairs on consecutive cycles; eos only on (6,0); first ovalid one cycle after accepting 3.
- Same stimulus with OFFBUF_CLAMP_EN defined -> last two pairs are (5,6),(6,6).
- Backpressure: oready=0 for 3 cycles while (2,4) is presented -> (2,4) held stable; iready=0 in RUN; no element lost or duplicated. During FILL, iready stays 1 with oready=0.
- ivalid toggled 1/0 every cycle through the whole stream -> identical output sequence to the first case. Outputs arrive only after accepts; counters do not advance on idle cycles.
- Two back-to-back streams 1..6 then 11..16 -> second stream yields (11,13)..(16,0). Element 11 is accepted the cycle after (6,0) is loaded, and no output of stream 1 is corrupted.
- rst pulsed for one cycle while in DRAIN with (5,0) held and oready=0 -> next cycle ovalid=0, eos=0, iready=1. A fresh stream 1..6 then produces the full first-case sequence.
